// File: rtl/trng_conditioner.sv
// TRNG conditioner: von Neumann debias, repetition-count health test, byte packer
// and a small byte FIFO behind a 4-bit-address / 8-bit-data register interface.
module trng_conditioner #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       health_fail
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    CUTOFF_C = 8'(RCT_CUTOFF);

  logic          enable_q, enable_d;
  logic          bypass_q, bypass_d;
  logic          hfail_q, hfail_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    dropped_q, dropped_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    pack_q, pack_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic          pair_valid_q, pair_valid_d;
  logic          pair_bit_q, pair_bit_d;
  logic          last_bit_q, last_bit_d;
  logic [7:0]    run_q, run_d;

  logic       ctrl_wr, stat_wr, clear, accept, full, empty, pop;
  logic       trip, emit, emit_bit, push, drop;
  logic [7:0] push_byte;
  logic       unused_data_bits;

  assign unused_data_bits = ^data_in[7:4];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ctrl_wr = data_write && (address == 4'd0);
  assign stat_wr = data_write && (address == 4'd1);
  assign clear   = ctrl_wr && data_in[2];
  assign accept  = enable_q && raw_valid && !clear;
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign pop     = data_read && (address == 4'd2) && !empty;

  always_comb begin
    enable_d     = enable_q;
    bypass_d     = bypass_q;
    hfail_d      = hfail_q;
    ovf_d        = ovf_q;
    dropped_d    = dropped_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pack_d       = pack_q;
    pcnt_d       = pcnt_q;
    pair_valid_d = pair_valid_q;
    pair_bit_d   = pair_bit_q;
    last_bit_d   = last_bit_q;
    run_d        = run_q;
    trip         = 1'b0;
    emit         = 1'b0;
    emit_bit     = 1'b0;
    push         = 1'b0;
    push_byte    = '0;
    drop         = 1'b0;

    // Health test sees every accepted raw bit; a trip swallows the sample and any partial state.
    if (accept) begin
      if (run_q == '0 || raw_bit != last_bit_q) begin
        run_d = 8'd1;
      end else if (run_q != 8'hFF) begin
        run_d = run_q + 8'd1;
      end
      last_bit_d = raw_bit;
      trip = (run_d == CUTOFF_C);
      if (trip) begin
        pack_d       = '0;
        pcnt_d       = '0;
        pair_valid_d = 1'b0;
      end else if (bypass_q) begin
        emit     = 1'b1;
        emit_bit = raw_bit;
      end else if (pair_valid_q) begin
        pair_valid_d = 1'b0;
        emit         = (pair_bit_q != raw_bit);
        emit_bit     = pair_bit_q;
      end else begin
        pair_valid_d = 1'b1;
        pair_bit_d   = raw_bit;
      end
    end

    if (emit) begin
      pack_d = {pack_q[5:0], emit_bit};
      pcnt_d = pcnt_q + 3'd1;
      if (pcnt_q == 3'd7) begin
        push      = 1'b1;
        push_byte = {pack_q, emit_bit};
      end
    end

    drop = push && full && !pop;
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !drop) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (push && !drop && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !(push && !drop)) begin
      count_d = count_q - 1'b1;
    end
    if (drop && dropped_q != 8'hFF) begin
      dropped_d = dropped_q + 8'd1;
    end

    // Set events are applied after W1C so a coincident set wins.
    if (stat_wr && data_in[2]) hfail_d = 1'b0;
    if (stat_wr && data_in[3]) ovf_d = 1'b0;
    if (trip) hfail_d = 1'b1;
    if (drop) ovf_d = 1'b1;

    if (ctrl_wr) begin
      enable_d = data_in[0];
      bypass_d = data_in[1];
    end

    if (clear) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      pack_d       = '0;
      pcnt_d       = '0;
      pair_valid_d = 1'b0;
      pair_bit_d   = 1'b0;
      last_bit_d   = 1'b0;
      run_d        = '0;
      dropped_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= 1'b0;
      bypass_q     <= 1'b0;
      hfail_q      <= 1'b0;
      ovf_q        <= 1'b0;
      dropped_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pack_q       <= '0;
      pcnt_q       <= '0;
      pair_valid_q <= 1'b0;
      pair_bit_q   <= 1'b0;
      last_bit_q   <= 1'b0;
      run_q        <= '0;
    end else begin
      enable_q     <= enable_d;
      bypass_q     <= bypass_d;
      hfail_q      <= hfail_d;
      ovf_q        <= ovf_d;
      dropped_q    <= dropped_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pack_q       <= pack_d;
      pcnt_q       <= pcnt_d;
      pair_valid_q <= pair_valid_d;
      pair_bit_q   <= pair_bit_d;
      last_bit_q   <= last_bit_d;
      run_q        <= run_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'd0: data_out = {6'b0, bypass_q, enable_q};
      4'd1: data_out = {4'(count_q), ovf_q, hfail_q, full, !empty};
      4'd2: data_out = empty ? 8'h00 : mem_q[rd_ptr_q];
      4'd3: data_out = dropped_q;
      default: data_out = 8'h00;
    endcase
  end

  assign data_ready  = !empty && enable_q;
  assign health_fail = hfail_q;

endmodule

// File: doc/trng_conditioner.md
Name: trng_conditioner

Overview:
- Downstream stage of the TRNG sampler. Consumes the raw entropy bit stream (one bit per raw_valid strobe).
- Applies von Neumann debiasing and a repetition-count health test, packs surviving bits into bytes, and buffers them in a small FIFO.
- Exposes control, status and data through the same 4-bit-address/8-bit-data register interface the SPI register bridge drives.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, maximum 8.
- RCT_CUTOFF, 16, number of consecutive identical raw bits that trips the health test; valid range 2..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- raw_bit  input  1  raw entropy sample; qualified by raw_valid.
- raw_valid  input  1  one-cycle strobe; raw_bit is valid this cycle.
- address  input  4  register address.
- data_write  input  1  one-cycle write strobe for data_in at address.
- data_in  input  8  write data.
- data_read  input  1  one-cycle read strobe; pops the FIFO when address==2.
- data_out  output  8  read data; combinational from address and register state.
- data_ready  output  1  FIFO non-empty AND CTRL.enable.
- health_fail  output  1  copy of the sticky STATUS health_fail bit.

Behaviour:
- Reset: all state is 0. This covers CTRL, sticky flags, the FIFO (count 0), the packer, the pair latch, the RCT counter and the drop counter. data_ready=0, health_fail=0, data_out=0x00.
- Register map:
  - 0x0 CTRL (RW): bit0 enable, bit1 bypass_debias. bit2 clear is write-only and self-clearing; it reads as 0.
  - 0x1 STATUS (RO, except W1C bits 2 and 3): bit0 nonempty, bit1 full, bit2 health_fail, bit3 overflow, bits7:4 FIFO count.
  - 0x2 DATA (RO): head byte, or 0x00 if empty.
  - 0x3 DROPPED (RO): count of dropped bytes, saturating at 255; cleared by CTRL.clear.
  - Other addresses read 0x00; writes to them are ignored.
- Register writes take effect at the clock edge of data_write.
- Clear: flushes the FIFO, packer, pair latch, RCT counter and DROPPED. It does not change the sticky flags.
- enable=0:
  - raw_valid is ignored; pipeline state holds.
  - The FIFO is still readable, but data_ready=0.
- Debias (bypass=0), operating on raw_valid bits:
  - First bit of a pair: latch it, emit nothing.
  - Second bit b with latched a: if a!=b, emit a; if equal, discard. The pair latch is then empty.
- Debias (bypass=1): every raw bit is emitted directly. Changing bypass does not flush the pair latch; a latched bit pairs with the next bit when bypass returns to 0.
- RCT health test:
  - Operates on every accepted raw bit, before debiasing.
  - The run counter resets to 1 on a change of value and increments on a repeat, saturating.
  - When it reaches RCT_CUTOFF: set health_fail sticky, discard the packer contents and the pair latch in that cycle, and emit no bit from that sample.
  - Generation continues afterwards.
- Packer:
  - Shifts emitted bits in MSB-first; the first emitted bit becomes data bit 7.
  - On the 8th bit the byte is pushed in the same edge; the packer count wraps to 0.
  - Push to visibility: the byte is visible at DATA and in STATUS count the cycle after the edge of the raw_valid that completed it.
- FIFO, push when full:
  - Without a simultaneous pop: drop the byte, set overflow sticky, DROPPED+1 (saturating).
  - With a simultaneous pop (data_read at address 2): both succeed, count unchanged, nothing dropped.
- FIFO pop:
  - Pop when empty: no effect, data_out=0x00.
  - Pops are only caused by data_read with address==2; reading other addresses never pops.
- W1C: writing 1 to STATUS bit2 or bit3 clears that flag. If a flag set-event and its W1C land in the same cycle, set wins.
- Mid-operation reset (rst_n low): asynchronously returns all state to reset values, regardless of in-flight bytes.

Test Plan:
- Reset, then write CTRL=0x03 (enable, bypass). Drive raw bits 1,0,1,1,0,0,1,0 → after the last strobe: STATUS=0x11, data_ready=1, DATA=0xB2. Pulse data_read at addr 2 → STATUS=0x00, data_ready=0.
- CTRL=0x01 (debias). Drive pairs 10,01,11,00,10,10,01,01,10,01 → 8 emitted bits 1,0,1,1,0,0,1,0 → DATA=0xB2; the 11/00 pairs are discarded.
- Bypass mode, FIFO_DEPTH=4. Push 5 bytes with no reads → STATUS bit1=1, bit3=1, count=4, DROPPED=1. On a 6th completion coinciding with data_read at addr 2 → count stays 4, DROPPED stays 1.
- Drive 16 consecutive raw 1s (RCT_CUTOFF=16) → health_fail=1 on the 16th strobe and the packer is emptied. Write STATUS=0x04 → health_fail=0. Write 0x04 in the same cycle as a new trip → stays 1.
- Partial byte (3 bits) plus 2 FIFO bytes, then write CTRL=0x05 (clear) → count=0, DROPPED=0, sticky flags unchanged. The next 8 bits form a fresh byte.
- Assert rst_n=0 asynchronously mid-byte with 3 bytes queued → data_out=0x00 and data_ready=0 immediately. After release, CTRL=0x00.
